// File: rtl/bcd_entry.sv
// N-digit signed BCD entry controller: digits entered LSD first on enter edges,
// with validation, cancel, idle timeout, previous-value retention and blink enables.
module bcd_entry #(
  parameter int DIGITS      = 3,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          digit_in,
  input  logic                sign_in,
  input  logic                enter,
  input  logic                cancel,
  output logic [4*DIGITS-1:0] value_bcd,
  output logic                value_sign,
  output logic [4*DIGITS-1:0] old_bcd,
  output logic                old_sign,
  output logic                value_valid,
  output logic                editing,
  output logic [3:0]          pos,
  output logic [4*DIGITS-1:0] edit_bcd,
  output logic [DIGITS-1:0]   digit_en,
  output logic                commit_pulse,
  output logic                reject_pulse
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [3:0]         POS_LAST   = 4'(DIGITS - 1);

  typedef enum logic {ST_ENTRY, ST_DONE} state_e;
  typedef logic [DIGITS-1:0][3:0] digits_t;

  state_e             state_q, state_d;
  logic [3:0]         pos_q, pos_d;
  digits_t            edit_buf_q, edit_buf_d;
  digits_t            value_q, value_d;
  digits_t            old_q, old_d;
  logic               value_sign_q, value_sign_d;
  logic               old_sign_q, old_sign_d;
  logic               value_valid_q, value_valid_d;
  logic               enter_prev_q, enter_prev_d;
  logic               cancel_prev_q, cancel_prev_d;
  logic               commit_pulse_q, commit_pulse_d;
  logic               reject_pulse_q, reject_pulse_d;
  logic               phase_q, phase_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic    enter_edge;
  logic    cancel_edge;
  logic    timeout_hit;
  digits_t commit_word;
  digits_t edit_img;
  logic [DIGITS-1:0] den;

  assign enter_edge  = enter && !enter_prev_q;
  assign cancel_edge = cancel && !cancel_prev_q;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt_q == IDLE_LAST);

  always_comb begin
    // NOTE: every _d starts from its held value so no path through this block can infer a latch.
    state_d        = state_q;
    pos_d          = pos_q;
    edit_buf_d     = edit_buf_q;
    value_d        = value_q;
    old_d          = old_q;
    value_sign_d   = value_sign_q;
    old_sign_d     = old_sign_q;
    value_valid_d  = value_valid_q;
    phase_d        = phase_q;
    blink_cnt_d    = blink_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    commit_pulse_d = 1'b0;
    reject_pulse_d = 1'b0;
    enter_prev_d   = enter;
    cancel_prev_d  = cancel;

    // Word that would be committed if the live digit completes the entry.
    commit_word = edit_buf_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (pos_q == 4'(k)) commit_word[k] = digit_in;
    end

    case (state_q)
      ST_ENTRY: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
        if (TIMEOUT_CYC != 0) idle_cnt_d = idle_cnt_q + IDLE_W'(1);

        // A timeout is indistinguishable from a cancel edge, and cancel beats enter.
        if (cancel_edge || timeout_hit) begin
          idle_cnt_d = '0;
          pos_d      = '0;
          if (value_valid_q) state_d = ST_DONE;
          else               edit_buf_d = '0;
        end else if (enter_edge) begin
          idle_cnt_d = '0;
          if (digit_in > 4'd9) begin
            reject_pulse_d = 1'b1;
          end else if (pos_q == POS_LAST) begin
            old_d          = value_q;
            old_sign_d     = value_sign_q;
            value_d        = commit_word;
            value_sign_d   = sign_in;
            value_valid_d  = 1'b1;
            commit_pulse_d = 1'b1;
            state_d        = ST_DONE;
            pos_d          = '0;
          end else begin
            edit_buf_d = commit_word;
            pos_d      = pos_q + 4'd1;
          end
        end
      end
      default: begin
        if (enter_edge) begin
          state_d     = ST_ENTRY;
          pos_d       = '0;
          edit_buf_d  = '0;
          phase_d     = 1'b1;
          blink_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ENTRY;
      pos_q          <= '0;
      edit_buf_q     <= '0;
      value_q        <= '0;
      old_q          <= '0;
      value_sign_q   <= 1'b0;
      old_sign_q     <= 1'b0;
      value_valid_q  <= 1'b0;
      enter_prev_q   <= 1'b0;
      cancel_prev_q  <= 1'b0;
      commit_pulse_q <= 1'b0;
      reject_pulse_q <= 1'b0;
      phase_q        <= 1'b1;
      blink_cnt_q    <= '0;
      idle_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values together.
      state_q        <= state_d;
      pos_q          <= pos_d;
      edit_buf_q     <= edit_buf_d;
      value_q        <= value_d;
      old_q          <= old_d;
      value_sign_q   <= value_sign_d;
      old_sign_q     <= old_sign_d;
      value_valid_q  <= value_valid_d;
      enter_prev_q   <= enter_prev_d;
      cancel_prev_q  <= cancel_prev_d;
      commit_pulse_q <= commit_pulse_d;
      reject_pulse_q <= reject_pulse_d;
      phase_q        <= phase_d;
      blink_cnt_q    <= blink_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  // Display image: entered digits, live digit at the cursor, blanks beyond it.
  always_comb begin
    edit_img = value_q;
    den      = '1;
    if (state_q == ST_ENTRY) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (4'(k) < pos_q) begin
          edit_img[k] = edit_buf_q[k];
        end else if (4'(k) == pos_q) begin
          edit_img[k] = digit_in;
          den[k]      = phase_q;
        end else begin
          edit_img[k] = 4'hF;
        end
      end
    end
  end

  assign value_bcd    = value_q;
  assign value_sign   = value_sign_q;
  assign old_bcd      = old_q;
  assign old_sign     = old_sign_q;
  assign value_valid  = value_valid_q;
  assign editing      = (state_q == ST_ENTRY);
  assign pos          = pos_q;
  assign edit_bcd     = edit_img;
  assign digit_en     = den;
  assign commit_pulse = commit_pulse_q;
  assign reject_pulse = reject_pulse_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Self-checking bench for bcd_entry: directed vector table, hand-written
// blink/timeout/reset sequences, and random actions against a digit-list model.
module tb_bcd_entry;

  localparam int D = 3;
  localparam int W = 4 * D;
  localparam int OP_E = 0;
  localparam int OP_C = 1;
  localparam int OP_B = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   digit_in = '0;
  logic         sign_in = 1'b0;
  logic         enter = 1'b0;
  logic         cancel = 1'b0;
  logic [W-1:0] value_bcd, old_bcd, edit_bcd;
  logic         value_sign, old_sign, value_valid, editing;
  logic [3:0]   pos;
  logic [D-1:0] digit_en;
  logic         commit_pulse, reject_pulse;

  bcd_entry #(.DIGITS(D), .BLINK_DIV(4), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .sign_in(sign_in),
    .enter(enter), .cancel(cancel), .value_bcd(value_bcd), .value_sign(value_sign),
    .old_bcd(old_bcd), .old_sign(old_sign), .value_valid(value_valid),
    .editing(editing), .pos(pos), .edit_bcd(edit_bcd), .digit_en(digit_en),
    .commit_pulse(commit_pulse), .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pc_commit, pc_reject;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: list of entered digits plus committed/old values.
  int         m_digs[$];
  logic [W-1:0] m_val, m_old;
  logic       m_vs, m_os, m_valid, m_edit;
  int         m_ec, m_er;

  task automatic model_reset();
    m_digs.delete();
    m_val = '0; m_old = '0; m_vs = 0; m_os = 0; m_valid = 0; m_edit = 1;
  endtask

  task automatic model_apply(input int op, input logic [3:0] d, input logic s);
    logic [W-1:0] word;
    m_ec = 0; m_er = 0;
    if (!m_edit) begin
      if (op != OP_C) begin
        m_edit = 1;
        m_digs.delete();
      end
    end else if (op != OP_E) begin
      if (m_valid) m_edit = 0;
      m_digs.delete();
    end else if (d > 9) begin
      m_er = 1;
    end else begin
      m_digs.push_back(int'(d));
      if (m_digs.size() == D) begin
        word = '0;
        for (int k = 0; k < D; k++) word = word + (W'(m_digs[k]) << (4 * k));
        m_old = m_val; m_os = m_vs;
        m_val = word;  m_vs = s;
        m_valid = 1; m_edit = 0; m_ec = 1;
        m_digs.delete();
      end
    end
  endtask

  function automatic logic [W-1:0] model_edit(input logic [3:0] live);
    logic [W-1:0] r;
    if (!m_edit) return m_val;
    r = '0;
    for (int k = 0; k < D; k++) begin
      if (k < m_digs.size())       r[4*k +: 4] = 4'(m_digs[k]);
      else if (k == m_digs.size()) r[4*k +: 4] = live;
      else                         r[4*k +: 4] = 4'hF;
    end
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    pc_commit += int'(commit_pulse);
    pc_reject += int'(reject_pulse);
  endtask

  task automatic do_action(input int op, input logic [3:0] d, input logic s, input int hold);
    pc_commit = 0; pc_reject = 0;
    digit_in = d; sign_in = s;
    enter  = (op != OP_C);
    cancel = (op != OP_E);
    repeat (hold) step();
    enter = 0; cancel = 0;
    repeat (2) step();
  endtask

  task automatic do_reset();
    enter = 0; cancel = 0; digit_in = 0; sign_in = 0;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_value"}, 32'(value_bcd), 32'(m_val));
    check({tag, "_vsign"}, 32'(value_sign), 32'(m_vs));
    check({tag, "_old"}, 32'(old_bcd), 32'(m_old));
    check({tag, "_osign"}, 32'(old_sign), 32'(m_os));
    check({tag, "_valid"}, 32'(value_valid), 32'(m_valid));
    check({tag, "_editing"}, 32'(editing), 32'(m_edit));
    check({tag, "_pos"}, 32'(pos), 32'(m_digs.size()));
    check({tag, "_edit_bcd"}, 32'(edit_bcd), 32'(model_edit(digit_in)));
    check({tag, "_commit"}, 32'(pc_commit), 32'(m_ec));
    check({tag, "_reject"}, 32'(pc_reject), 32'(m_er));
    if (m_edit) check({tag, "_den"}, 32'(digit_en | (D'(1) << m_digs.size())), 32'({D{1'b1}}));
    else        check({tag, "_den"}, 32'(digit_en), 32'({D{1'b1}}));
  endtask

  typedef struct {
    int op; logic [3:0] d; logic s;
    logic [W-1:0] v; logic vs; logic [W-1:0] o; logic os;
    logic valid; logic ed; logic [3:0] p; int nc; int nr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int changes, last_i, i;
    logic last_en;

    tbl[0]  = '{OP_E, 4'd5, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd1, 0, 0};
    tbl[1]  = '{OP_E, 4'd2, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd2, 0, 0};
    tbl[2]  = '{OP_E, 4'd1, 1'b1, 12'h125, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 4'd0, 1, 0};
    tbl[3]  = '{OP_E, 4'd0, 1'b0, 12'h125, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 4'd0, 0, 0};
    tbl[4]  = '{OP_E, 4'd7, 1'b0, 12'h125, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 4'd1, 0, 0};
    tbl[5]  = '{OP_E, 4'hB, 1'b0, 12'h125, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 4'd1, 0, 1};
    tbl[6]  = '{OP_E, 4'd0, 1'b0, 12'h125, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 4'd2, 0, 0};
    tbl[7]  = '{OP_E, 4'd3, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b0, 4'd0, 1, 0};
    tbl[8]  = '{OP_E, 4'd0, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b1, 4'd0, 0, 0};
    tbl[9]  = '{OP_E, 4'd9, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b1, 4'd1, 0, 0};
    tbl[10] = '{OP_C, 4'd9, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b0, 4'd0, 0, 0};
    tbl[11] = '{OP_C, 4'd9, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b0, 4'd0, 0, 0};
    tbl[12] = '{OP_E, 4'd0, 1'b0, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b1, 4'd0, 0, 0};
    tbl[13] = '{OP_E, 4'd4, 1'b1, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b1, 4'd1, 0, 0};
    tbl[14] = '{OP_E, 4'd6, 1'b1, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b1, 4'd2, 0, 0};
    tbl[15] = '{OP_B, 4'd8, 1'b1, 12'h307, 1'b0, 12'h125, 1'b1, 1'b1, 1'b0, 4'd0, 0, 0};

    // Reset state, checked before any clock edge after release.
    do_reset();
    #1;
    check("rst_editing", 32'(editing), 32'd1);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_value", 32'(value_bcd), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_old", 32'(old_bcd), 32'd0);
    check("rst_den", 32'(digit_en), 32'h7);
    check("rst_pulses", 32'({commit_pulse, reject_pulse}), 32'd0);
    check("rst_edit_bcd", 32'(edit_bcd), 32'hFF0);

    // Directed vector table.
    for (int r = 0; r < 16; r++) begin
      do_action(tbl[r].op, tbl[r].d, tbl[r].s, 1);
      model_apply(tbl[r].op, tbl[r].d, tbl[r].s);
      check($sformatf("tbl%0d_value", r), 32'(value_bcd), 32'(tbl[r].v));
      check($sformatf("tbl%0d_vsign", r), 32'(value_sign), 32'(tbl[r].vs));
      check($sformatf("tbl%0d_old", r), 32'(old_bcd), 32'(tbl[r].o));
      check($sformatf("tbl%0d_osign", r), 32'(old_sign), 32'(tbl[r].os));
      check($sformatf("tbl%0d_valid", r), 32'(value_valid), 32'(tbl[r].valid));
      check($sformatf("tbl%0d_editing", r), 32'(editing), 32'(tbl[r].ed));
      check($sformatf("tbl%0d_pos", r), 32'(pos), 32'(tbl[r].p));
      check($sformatf("tbl%0d_commit", r), 32'(pc_commit), 32'(tbl[r].nc));
      check($sformatf("tbl%0d_reject", r), 32'(pc_reject), 32'(tbl[r].nr));
      check($sformatf("tbl%0d_edit_bcd", r), 32'(edit_bcd), 32'(model_edit(digit_in)));
    end

    // Cancel with nothing committed restarts the entry.
    do_reset();
    do_action(OP_C, 4'd2, 1'b0, 1);
    check("cancel_empty_editing", 32'(editing), 32'd1);
    check("cancel_empty_pos", 32'(pos), 32'd0);
    do_action(OP_E, 4'd8, 1'b0, 1);
    do_action(OP_C, 4'd2, 1'b0, 1);
    check("cancel_restart_pos", 32'(pos), 32'd0);
    check("cancel_restart_edit", 32'(edit_bcd), 32'hFF2);

    // Held enter levels act only once.
    do_action(OP_E, 4'd3, 1'b0, 1);
    do_action(OP_E, 4'hB, 1'b0, 10);
    check("held_reject_count", 32'(pc_reject), 32'd1);
    check("held_reject_pos", 32'(pos), 32'd1);
    check("held_reject_edit", 32'(edit_bcd), 32'hFB3);
    do_action(OP_E, 4'd6, 1'b0, 10);
    check("held_digit_pos", 32'(pos), 32'd2);
    check("held_digit_commit", 32'(pc_commit), 32'd0);
    check("held_digit_edit", 32'(edit_bcd), 32'h663);

    // Blink period and idle timeout with a committed value present.
    do_reset();
    do_action(OP_E, 4'd1, 1'b0, 1);
    do_action(OP_E, 4'd2, 1'b0, 1);
    do_action(OP_E, 4'd3, 1'b0, 1);
    check("to_commit_value", 32'(value_bcd), 32'h321);
    do_action(OP_E, 4'd0, 1'b0, 1);
    digit_in = 4'd4;
    enter = 1;
    changes = 0; last_i = 0; last_en = 1'b0;
    for (i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 2) enter = 0;
      if (!editing) break;
      if (i > 1 && digit_en[1] != last_en) begin
        if (changes > 0) check($sformatf("blink_interval%0d", changes), 32'(i - last_i), 32'd4);
        changes++;
        last_i = i;
      end
      last_en = digit_en[1];
    end
    check("blink_toggles_seen", 32'(changes >= 3), 32'd1);
    check("timeout_cycle", 32'(i), 32'd21);
    check("timeout_editing", 32'(editing), 32'd0);
    check("timeout_value", 32'(value_bcd), 32'h321);
    check("timeout_pos", 32'(pos), 32'd0);
    enter = 0;

    // Asynchronous reset in the middle of an entry.
    do_action(OP_E, 4'd0, 1'b0, 1);
    do_action(OP_E, 4'd7, 1'b1, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_editing", 32'(editing), 32'd1);
    check("async_rst_pos", 32'(pos), 32'd0);
    check("async_rst_value", 32'(value_bcd), 32'd0);
    check("async_rst_valid", 32'(value_valid), 32'd0);
    check("async_rst_old", 32'(old_bcd), 32'd0);
    check("async_rst_edit", 32'(edit_bcd), 32'hFF7);

    // Random actions against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r, op, hold;
      logic [3:0] d;
      logic s;
      r  = int'($urandom_range(0, 99));
      op = (r < 8) ? OP_C : (r < 12) ? OP_B : OP_E;
      d  = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      s  = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 2));
      do_action(op, d, s, hold);
      model_apply(op, d, s);
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
